// File: rtl/image_sensor_interface.sv
// Frame-capture front end for a raw 8-bit sensor: buffers one frame's pixels
// in a small FIFO and presents them level-shifted to signed 9-bit samples.
module image_sensor_interface #(
  parameter int FRAME_PIXELS = 1024,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       in_HCLK,
  input  logic       in_HRESET,
  input  logic       in_frame_capture,
  input  logic       in_pix_valid,
  input  logic [7:0] in_pix_data,
  input  logic       in_data_ack,
  output logic [8:0] out_data_read,
  output logic       out_data_valid,
  output logic       out_done,
  output logic       out_busy,
  output logic       out_overflow
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = AW + 1;
  localparam int CW = $clog2(FRAME_PIXELS + 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [OW-1:0] occ_reg;
  logic          overflow_reg;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [7:0]    head;

  logic start, attempt, pop, full, push;

  assign start   = (state_reg == IDLE) && in_frame_capture;
  assign attempt = (state_reg == CAPTURE) && in_pix_valid && (count_reg < CW'(FRAME_PIXELS));
  assign pop     = out_data_valid && in_data_ack;
  assign full    = (occ_reg == OW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push    = attempt && (!full || pop);

  always_ff @(posedge in_HCLK) begin
    if (push) mem[wr_ptr_reg] <= in_pix_data;
  end

  always_ff @(posedge in_HCLK or posedge in_HRESET) begin
    if (in_HRESET) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      occ_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        count_reg    <= '0;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        occ_reg      <= '0;
        overflow_reg <= 1'b0;
      end else begin
        if (attempt) count_reg <= count_reg + CW'(1);
        if (attempt && full && !pop) overflow_reg <= 1'b1;
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
        case ({push, pop})
          2'b10:   occ_reg <= occ_reg + OW'(1);
          2'b01:   occ_reg <= occ_reg - OW'(1);
          default: occ_reg <= occ_reg;
        endcase
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    out_done   = 1'b0;
    out_busy   = (state_reg != IDLE);
    case (state_reg)
      IDLE:    if (in_frame_capture) state_next = CAPTURE;
      CAPTURE: if (attempt && (count_reg == CW'(FRAME_PIXELS - 1))) state_next = DRAIN;
      DRAIN:   if (occ_reg == '0) state_next = DONE;
      DONE: begin
        out_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // An empty FIFO presents a zero head so the reset/empty output is 9'h180.
  assign out_data_valid = (occ_reg != '0);
  assign head           = out_data_valid ? mem[rd_ptr_reg] : 8'd0;
  assign out_data_read  = {1'b0, head} - 9'd128;
  assign out_overflow   = overflow_reg;

endmodule

// File: tb/tb_image_sensor_interface.sv
// Randomized bench for image_sensor_interface against a queue-based frame model.
module tb_image_sensor_interface;
  localparam int N = 1024;
  localparam int D = 16;
  localparam int P_IDLE = 0, P_CAP = 1, P_DRAIN = 2, P_DONE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cap = 1'b0, pv = 1'b0, ack = 1'b0;
  logic [7:0] pd = 8'd0;
  logic [8:0] rd;
  logic       dv, done, busy, ovf;

  always #5 clk = ~clk;

  image_sensor_interface #(.FRAME_PIXELS(N), .FIFO_DEPTH(D)) dut (
    .in_HCLK(clk), .in_HRESET(rst), .in_frame_capture(cap), .in_pix_valid(pv),
    .in_pix_data(pd), .in_data_ack(ack), .out_data_read(rd), .out_data_valid(dv),
    .out_done(done), .out_busy(busy), .out_overflow(ovf)
  );

  int vectors = 0;
  int miscompares = 0;

  // Frame model: buffered pixels, pixels seen this frame, sticky overflow, phase.
  byte unsigned q[$];
  int  cnt = 0;
  bit  m_ovf = 1'b0;
  int  phase = P_IDLE;
  int  done_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [8:0] exp_rd;
    check("data_valid", dv, (q.size() != 0));
    if (q.size() != 0) begin
      exp_rd = {1'b0, q[0]} - 9'd128;
      check("data_read", rd, exp_rd);
    end
    check("done", done, (phase == P_DONE));
    check("busy", busy, (phase != P_IDLE));
    check("overflow", ovf, m_ovf);
    if (done === 1'b1) done_seen++;
  endtask

  // One clock: check, drive, advance the model, then move to the next falling edge.
  task automatic step(input bit c, input bit v, input byte unsigned d, input bit a);
    bit pop, att, was_full, was_empty;
    compare_outputs();
    cap = c; pv = v; pd = d; ack = a;
    if (phase == P_IDLE && c) begin
      q.delete(); cnt = 0; m_ovf = 1'b0; phase = P_CAP;
    end else begin
      was_empty = (q.size() == 0);
      was_full  = (q.size() == D);
      pop = a && !was_empty;
      att = (phase == P_CAP) && v && (cnt < N);
      if (phase == P_DONE) phase = P_IDLE;
      else if (phase == P_DRAIN && was_empty) phase = P_DONE;
      if (pop) void'(q.pop_front());
      if (att) begin
        if (was_full && !pop) m_ovf = 1'b1;
        else q.push_back(d);
        cnt++;
        if (cnt == N) phase = P_DRAIN;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic finish_frame(input int vprob, input int aprob, input bit ramp);
    int guard = 0;
    while (phase != P_IDLE && guard < 20000) begin
      step(($urandom_range(7) == 0), ($urandom_range(99) < vprob),
           ramp ? byte'(cnt) : byte'($urandom), ($urandom_range(99) < aprob));
      guard++;
    end
    step(1'b0, 1'b0, 8'd0, 1'b0);
    check("frame_timeout", (guard < 20000), 1);
    check("done_pulses", done_seen, 1);
  endtask

  task automatic start_frame();
    done_seen = 0;
    step(1'b1, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    compare_outputs();
    check("reset_read", rd, 9'h180);
    rst = 1'b0;
    step(1'b0, 1'b1, 8'h55, 1'b1);  // pixel while idle is ignored

    // Nominal ramp frame, ack held high
    start_frame();
    finish_frame(100, 100, 1'b1);
    check("nominal_ovf", ovf, 0);

    // Overflow: 20 pixels with no ack
    start_frame();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, byte'(i + 1), 1'b0);
    check("ovf_set", ovf, 1);
    check("ovf_head", rd, 9'(9'd1 - 9'd128));
    finish_frame(60, 70, 1'b0);

    // Full FIFO with simultaneous push and pop
    start_frame();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, byte'(i + 100), 1'b0);
    step(1'b0, 1'b1, 8'd200, 1'b1);
    check("full_pushpop_ovf", ovf, 0);
    check("full_pushpop_head", rd, 9'(9'd101 - 9'd128));
    finish_frame(70, 60, 1'b0);

    // Boundary pixel values
    start_frame();
    step(1'b0, 1'b1, 8'd0, 1'b0);
    step(1'b0, 1'b1, 8'd128, 1'b0);
    step(1'b0, 1'b1, 8'd255, 1'b0);
    check("bound_0", rd, 9'h180);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    check("bound_128", rd, 9'h000);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    check("bound_255", rd, 9'h07F);
    finish_frame(80, 80, 1'b0);

    // Reset after 500 pixels
    start_frame();
    while (cnt < 500) step(1'b0, 1'b1, byte'($urandom), ($urandom_range(1) == 1));
    #2 rst = 1'b1;
    #1;
    check("rst_valid", dv, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_read", rd, 9'h180);
    q.delete(); cnt = 0; m_ovf = 1'b0; phase = P_IDLE; done_seen = 0;
    @(negedge clk);
    compare_outputs();
    rst = 1'b0;
    step(1'b0, 1'b0, 8'd0, 1'b0);
    check("rst_no_done", done_seen, 0);
    start_frame();
    finish_frame(100, 100, 1'b1);

    // Randomized frames, including overflow-heavy ones
    start_frame();
    finish_frame(80, 30, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b1);  // overflow persists in idle
    start_frame();
    finish_frame(50, 90, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
